stopwatch_control: RTL and testbench

//  Upstream control stage for the stopwatch counter/decoder block. Conditions three raw

---
 rtl/stopwatch_control.sv | 155 +++++++++++++++
 tb/tb_stopwatch_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_control.sv
// stopwatch_control
//   Front-end control for the stopwatch counter/decoder block. Debounces the
//   three raw push-buttons, turns each accepted press into a one-cycle event,
//   and runs the run/stop/lap/clear state machine that gates the digit counters.
//
// Ports
//   clk             in   1  system clock, rising edge
//   reset           in   1  synchronous, active-high
//   start_stop_btn  in   1  raw start/stop button, active-high, async to clk
//   lap_btn         in   1  raw lap button, active-high, async to clk
//   clear_btn       in   1  raw clear button, active-high, async to clk
//   device_running  out  1  high in RUNNING and LAP (gates the 0.01 s prescaler)
//   display_hold    out  1  high in LAP (freezes the 7-seg outputs)
//   counter_clear   out  1  one-cycle pulse zeroing the digit counters
//   state           out  2  current FSM state
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | 00  counters cleared, not timing
// RUNNING | 01  timing, display live
// STOPPED | 10  timing paused, value shown
// LAP     | 11  timing continues, display frozen

module stopwatch_control #(
  parameter int DEBOUNCE_CYCLES = 260000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop_btn,
  input  logic       lap_btn,
  input  logic       clear_btn,
  output logic       device_running,
  output logic       display_hold,
  output logic       counter_clear,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    STOPPED = 2'b10,
    LAP     = 2'b11
  } state_t;

  localparam int BTN_START = 0;
  localparam int BTN_LAP   = 1;
  localparam int BTN_CLEAR = 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           cur;
  logic [2:0]       raw;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       db;
  logic [2:0]       db_q;
  logic [2:0]       press;
  logic [CNT_W-1:0] cnt [3];

  assign raw = {clear_btn, lap_btn, start_stop_btn};

  // Synchroniser and debounce for all three buttons. A level is accepted only
  // after s2 has disagreed with db for DEBOUNCE_CYCLES consecutive cycles; any
  // return to agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases produce no event.
  // db_q is cleared with db, so a button held through reset re-fires.
  assign press = db & ~db_q;

  // Within each state the first matching branch wins, which gives
  // start_stop > lap > clear among the events legal in that state; the rest
  // of a coincident group is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur            <= IDLE;
      device_running <= 1'b0;
      display_hold   <= 1'b0;
      counter_clear  <= 1'b0;
    end else begin
      counter_clear <= 1'b0;
      case (cur)
        IDLE: begin
          if (press[BTN_START]) begin
            cur            <= RUNNING;
            device_running <= 1'b1;
          end else if (press[BTN_CLEAR]) begin
            counter_clear <= 1'b1;
          end
        end
        RUNNING: begin
          if (press[BTN_START]) begin
            cur            <= STOPPED;
            device_running <= 1'b0;
          end else if (press[BTN_LAP]) begin
            cur          <= LAP;
            display_hold <= 1'b1;
          end
        end
        LAP: begin
          if (press[BTN_START]) begin
            cur            <= STOPPED;
            device_running <= 1'b0;
            display_hold   <= 1'b0;
          end else if (press[BTN_LAP]) begin
            cur          <= RUNNING;
            display_hold <= 1'b0;
          end
        end
        STOPPED: begin
          if (press[BTN_START]) begin
            cur            <= RUNNING;
            device_running <= 1'b1;
          end else if (press[BTN_CLEAR]) begin
            cur           <= IDLE;
            counter_clear <= 1'b1;
          end
        end
        default: begin
          cur            <= IDLE;
          device_running <= 1'b0;
          display_hold   <= 1'b0;
        end
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stopwatch_control.sv
// tb_stopwatch_control
//   Directed bench for stopwatch_control with DEBOUNCE_CYCLES=4, CNT_W=3.
//   Inputs change just after a falling edge; outputs are sampled on falling
//   edges, so "after edge N" means the falling edge following rising edge N.

module tb_stopwatch_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop_btn;
  logic       lap_btn;
  logic       clear_btn;
  logic       device_running;
  logic       display_hold;
  logic       counter_clear;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int clear_pulses = 0;
  int pulses_before;

  localparam logic [2:0] B_START = 3'b001;
  localparam logic [2:0] B_LAP   = 3'b010;
  localparam logic [2:0] B_CLEAR = 3'b100;

  stopwatch_control #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_stop_btn(start_stop_btn),
    .lap_btn       (lap_btn),
    .clear_btn     (clear_btn),
    .device_running(device_running),
    .display_hold  (display_hold),
    .counter_clear (counter_clear),
    .state         (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (counter_clear === 1'b1) clear_pulses++;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_btns(input logic [2:0] m);
    start_stop_btn = m[0];
    lap_btn        = m[1];
    clear_btn      = m[2];
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: held 8 cycles (event lands at edge 7), then a long release.
  task automatic do_press(input logic [2:0] m);
    set_btns(m);
    cycles(8);
    set_btns(3'b000);
    cycles(10);
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st,
                            input logic run, input logic hold);
    check({tag, "_state"}, {6'd0, state}, {6'd0, st});
    check({tag, "_running"}, {7'd0, device_running}, {7'd0, run});
    check({tag, "_hold"}, {7'd0, display_hold}, {7'd0, hold});
  endtask

  initial begin
    reset = 1'b1;
    set_btns(3'b000);
    cycles(3);
    check_outs("reset", 2'b00, 1'b0, 1'b0);
    check("reset_clear", {7'd0, counter_clear}, 8'd0);
    reset = 1'b0;
    cycles(2);

    // 1: clean 20-cycle hold of start -> exactly one transition at edge 7
    set_btns(B_START);
    cycles(6);
    check("t1_edge6_state", {6'd0, state}, 8'd0);
    cycles(1);
    check_outs("t1_edge7", 2'b01, 1'b1, 1'b0);
    cycles(13);
    set_btns(3'b000);
    cycles(10);
    check_outs("t1_after_hold", 2'b01, 1'b1, 1'b0);

    // 2: 3-cycle glitch from IDLE is rejected
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);
    set_btns(B_START);
    cycles(3);
    set_btns(3'b000);
    cycles(12);
    check_outs("t2_glitch", 2'b00, 1'b0, 1'b0);

    // 3: run, lap in, lap out
    do_press(B_START);
    check_outs("t3_run", 2'b01, 1'b1, 1'b0);
    do_press(B_LAP);
    check_outs("t3_lap", 2'b11, 1'b1, 1'b1);
    do_press(B_LAP);
    check_outs("t3_unlap", 2'b01, 1'b1, 1'b0);

    // LAP + start -> STOPPED with display released
    do_press(B_LAP);
    check_outs("lap_again", 2'b11, 1'b1, 1'b1);
    do_press(B_START);
    check_outs("lap_stop", 2'b10, 1'b0, 1'b0);

    // 4: clear from STOPPED gives exactly one pulse
    pulses_before = clear_pulses;
    set_btns(B_CLEAR);
    cycles(6);
    check("t4_edge6_clear", {7'd0, counter_clear}, 8'd0);
    cycles(1);
    check("t4_edge7_clear", {7'd0, counter_clear}, 8'd1);
    check("t4_edge7_state", {6'd0, state}, 8'd0);
    cycles(1);
    check("t4_edge8_clear", {7'd0, counter_clear}, 8'd0);
    set_btns(3'b000);
    cycles(10);
    check("t4_pulse_count", 8'(clear_pulses - pulses_before), 8'd1);

    // lap ignored in IDLE
    do_press(B_LAP);
    check_outs("idle_lap", 2'b00, 1'b0, 1'b0);

    // clear ignored in RUNNING
    do_press(B_START);
    pulses_before = clear_pulses;
    do_press(B_CLEAR);
    check_outs("run_clear", 2'b01, 1'b1, 1'b0);
    check("run_clear_pulses", 8'(clear_pulses - pulses_before), 8'd0);

    // 5: STOPPED, start+clear together -> start wins, no clear pulse
    do_press(B_START);
    check_outs("t5_stopped", 2'b10, 1'b0, 1'b0);
    pulses_before = clear_pulses;
    do_press(B_START | B_CLEAR);
    check_outs("t5_both", 2'b01, 1'b1, 1'b0);
    check("t5_pulses", 8'(clear_pulses - pulses_before), 8'd0);

    // 6: reset mid-debounce (count at 2) with button held; refire after 7 edges
    do_press(B_START);
    do_press(B_START);
    check_outs("t6_pre", 2'b01, 1'b1, 1'b0);
    set_btns(B_START);
    cycles(4);
    reset = 1'b1;
    cycles(3);
    check_outs("t6_in_reset", 2'b00, 1'b0, 1'b0);
    check("t6_reset_clear", {7'd0, counter_clear}, 8'd0);
    reset = 1'b0;
    cycles(6);
    check("t6_edge6_state", {6'd0, state}, 8'd0);
    cycles(1);
    check_outs("t6_edge7", 2'b01, 1'b1, 1'b0);
    set_btns(3'b000);
    cycles(10);
    check_outs("t6_end", 2'b01, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
